// File: rtl/hlsm_job_sequencer_if.sv
// hlsm_job_sequencer_if: job intake, result output and core-side signals of the HLSM job sequencer
interface hlsm_job_sequencer_if #(parameter int W = 16);
    logic in_valid, in_ready, out_valid, out_ready, out_err;
    logic core_rst, core_start, core_done;
    logic signed [W-1:0] in_a, in_b, in_c, in_d, in_e, in_f;
    logic signed [W-1:0] core_a, core_b, core_c, core_d, core_e, core_f;
    logic signed [W-1:0] out_j, out_k, core_j, core_k;
    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_e, in_f, out_ready, core_done, core_j, core_k,
        input  in_ready, out_valid, out_j, out_k, out_err, core_rst, core_start,
        input  core_a, core_b, core_c, core_d, core_e, core_f
    );
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_e, in_f, out_ready, core_done, core_j, core_k,
        output in_ready, out_valid, out_j, out_k, out_err, core_rst, core_start,
        output core_a, core_b, core_c, core_d, core_e, core_f
    );
endinterface

// File: rtl/hlsm_job_sequencer.sv
// hlsm_job_sequencer: launches one operand job into the HLSM core and collects j/k into a one-entry output
module hlsm_job_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input logic Clk,
    input logic Rst,
    hlsm_job_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;
    logic [1:0] state;
    logic [CNT_W-1:0] run_cnt;
    logic err_pend, done_q, slot_free, cap;
    logic signed [W-1:0] cap_j, cap_k;
    // Done is stale from the previous job until the core has taken a couple of steps
    assign done_q         = bus.core_done && (run_cnt >= CNT_W'(2));
    assign slot_free      = !bus.out_valid || bus.out_ready;
    assign cap            = slot_free && ((state == RUN && done_q) || state == DRAIN);
    assign cap_j          = err_pend ? '0 : bus.core_j;
    assign cap_k          = err_pend ? '0 : bus.core_k;
    assign bus.in_ready   = state == IDLE;
    assign bus.core_start = state == RUN && !done_q;
    assign bus.core_rst   = Rst || state == ABORT;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            run_cnt       <= '0;
            err_pend      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_j     <= '0;
            bus.out_k     <= '0;
            bus.core_a    <= '0;
            bus.core_b    <= '0;
            bus.core_c    <= '0;
            bus.core_d    <= '0;
            bus.core_e    <= '0;
            bus.core_f    <= '0;
        end else begin
            if (cap) begin
                bus.out_valid <= 1'b1;
                bus.out_j     <= cap_j;
                bus.out_k     <= cap_k;
                bus.out_err   <= err_pend;
                err_pend      <= 1'b0;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                IDLE: if (bus.in_valid) begin
                    bus.core_a <= bus.in_a;
                    bus.core_b <= bus.in_b;
                    bus.core_c <= bus.in_c;
                    bus.core_d <= bus.in_d;
                    bus.core_e <= bus.in_e;
                    bus.core_f <= bus.in_f;
                    run_cnt    <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (done_q) state <= slot_free ? IDLE : DRAIN;
                    else if (run_cnt == CNT_W'(TIMEOUT - 1)) state <= ABORT;
                end
                DRAIN: if (slot_free) state <= IDLE;
                default: begin
                    err_pend <= 1'b1;
                    state    <= DRAIN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// tb_hlsm_job_sequencer: directed and randomized jobs checked every cycle against a job-timeline model
module tb_hlsm_job_sequencer;
    localparam int W = 16;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic hang = 1'b0;
    int checks = 0;
    int errors = 0;
    hlsm_job_sequencer_if #(.W(W)) bus ();
    hlsm_job_sequencer #(.W(W), .TIMEOUT(32), .CNT_W(6)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
    always #5 Clk = ~Clk;
    // Core stand-in: 12 Start-qualified steps, Done held until the next job's first step
    logic [3:0] step;
    always @(posedge Clk) begin
        if (bus.core_rst) begin
            step          <= 4'd0;
            bus.core_done <= 1'b0;
            bus.core_j    <= '0;
            bus.core_k    <= '0;
        end else if (bus.core_start) begin
            if (step == 4'd0) bus.core_done <= 1'b0;
            if (step != 4'd11) step <= step + 4'd1;
            else if (!hang) begin
                step          <= 4'd0;
                bus.core_done <= 1'b1;
                bus.core_j    <= (bus.core_a * bus.core_b + bus.core_c) * bus.core_d;
                bus.core_k    <= bus.core_e * bus.core_f;
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask
    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    // Model: a job runs from its accept edge; its result may be captured once it is old enough
    // (12 cycles normally, 33 when the core hangs) and the output slot is free
    logic act = 1'b0, hng = 1'b0, ov = 1'b0, oe = 1'b0;
    logic [W-1:0] oj = '0, ok = '0, rj = '0, rk = '0;
    logic [W-1:0] ops [6] = '{default: '0};
    int ecnt = 0, jedge = 0;
    always @(negedge Clk) begin
        int d;
        logic was, free;
        d = ecnt - jedge;
        chk("in_ready", int'(bus.in_ready), int'(!act));
        chk("out_valid", int'(bus.out_valid), int'(ov));
        chk("out_err", int'(bus.out_err), int'(oe));
        chkw("out_j", bus.out_j, oj);
        chkw("out_k", bus.out_k, ok);
        chk("core_start", int'(bus.core_start), int'(act && d < (hng ? 32 : 12)));
        chk("core_rst", int'(bus.core_rst), int'(Rst || (act && hng && d == 32)));
        chkw("core_a", bus.core_a, ops[0]);
        chkw("core_b", bus.core_b, ops[1]);
        chkw("core_c", bus.core_c, ops[2]);
        chkw("core_d", bus.core_d, ops[3]);
        chkw("core_e", bus.core_e, ops[4]);
        chkw("core_f", bus.core_f, ops[5]);
        ecnt++;
        if (Rst) begin
            act = 1'b0;
            ov  = 1'b0;
            oe  = 1'b0;
            oj  = '0;
            ok  = '0;
            ops = '{default: '0};
        end else begin
            was  = act;
            free = !ov || bus.out_ready;
            if (act && d >= (hng ? 33 : 12) && free) begin
                ov  = 1'b1;
                oe  = hng;
                oj  = hng ? '0 : rj;
                ok  = hng ? '0 : rk;
                act = 1'b0;
            end else if (ov && bus.out_ready) ov = 1'b0;
            if (!was && bus.in_valid) begin
                act   = 1'b1;
                hng   = hang;
                jedge = ecnt;
                ops   = '{bus.in_a, bus.in_b, bus.in_c, bus.in_d, bus.in_e, bus.in_f};
                rj    = (bus.in_a * bus.in_b + bus.in_c) * bus.in_d;
                rk    = bus.in_e * bus.in_f;
            end
        end
    end
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] a, b, c, d, e, f);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        bus.in_valid = 1'b1;
        {bus.in_a, bus.in_b, bus.in_c, bus.in_d, bus.in_e, bus.in_f} = {a, b, c, d, e, f};
        tick();
        bus.in_valid = 1'b0;
        {bus.in_a, bus.in_b, bus.in_c} = {16'($urandom), 16'($urandom), 16'($urandom)};
        {bus.in_d, bus.in_e, bus.in_f} = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask
    task automatic await_out(output int n, output int starts);
        n = 0;
        starts = 0;
        while (!bus.out_valid && n < 100) begin
            starts += int'(bus.core_start);
            tick();
            n++;
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int n, starts;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        {bus.in_a, bus.in_b, bus.in_c, bus.in_d, bus.in_e, bus.in_f} = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_core_start", int'(bus.core_start), 0);
        send(2, 3, 4, 5, 6, 7);
        await_out(n, starts);
        chk("t1_latency", n, 13);
        chk("t1_start_cycles", starts, 12);
        chkw("t1_j", bus.out_j, 16'd50);
        chkw("t1_k", bus.out_k, 16'd42);
        chk("t1_err", int'(bus.out_err), 0);
        send(300, 300, 0, 2, -2, 3);
        chk("t5_stale_done", int'(bus.core_done), 1);
        await_out(n, starts);
        chk("t5_latency", n, 13);
        chkw("t2_j", bus.out_j, 16'hBF20);
        chkw("t2_k", bus.out_k, 16'hFFFA);
        tick();
        bus.out_ready = 1'b0;
        send(1, 1, 1, 1, 1, 5);
        await_out(n, starts);
        send(2, 2, 2, 2, 3, 3);
        repeat (20) tick();
        chk("t3_drain_start", int'(bus.core_start), 0);
        chkw("t3_hold_j", bus.out_j, 16'd2);
        chkw("t3_hold_k", bus.out_k, 16'd5);
        bus.out_ready = 1'b1;
        tick();
        chk("t3_valid", int'(bus.out_valid), 1);
        chkw("t3_j2", bus.out_j, 16'd12);
        chkw("t3_k2", bus.out_k, 16'd9);
        tick();
        hang = 1'b1;
        send(1, 2, 3, 4, 5, 6);
        n = 0;
        while (!bus.core_rst && n < 100) begin
            tick();
            n++;
        end
        chk("t4_abort_at", n, 32);
        tick();
        chk("t4_rst_pulse_end", int'(bus.core_rst), 0);
        tick();
        chk("t4_valid", int'(bus.out_valid), 1);
        chk("t4_err", int'(bus.out_err), 1);
        chkw("t4_j", bus.out_j, 16'd0);
        chkw("t4_k", bus.out_k, 16'd0);
        hang = 1'b0;
        send(2, 3, 4, 5, 6, 7);
        await_out(n, starts);
        chk("t4_next_latency", n, 13);
        chkw("t4_next_j", bus.out_j, 16'd50);
        send(2, 3, 4, 5, 6, 7);
        repeat (5) tick();
        Rst = 1'b1;
        #1 chk("t6_core_rst", int'(bus.core_rst), 1);
        tick();
        Rst = 1'b0;
        chk("t6_in_ready", int'(bus.in_ready), 1);
        chk("t6_out_valid", int'(bus.out_valid), 0);
        send(3, 3, 3, 3, 3, 3);
        await_out(n, starts);
        chk("t6_latency", n, 13);
        chkw("t6_j", bus.out_j, 16'd36);
        chkw("t6_k", bus.out_k, 16'd9);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            bus.in_valid  = $urandom_range(0, 3) != 0;
            {bus.in_a, bus.in_b, bus.in_c} = {16'($urandom), 16'($urandom), 16'($urandom)};
            {bus.in_d, bus.in_e, bus.in_f} = {16'($urandom), 16'($urandom), 16'($urandom)};
            bus.out_ready = $urandom_range(0, 2) != 0;
            if (bus.in_ready) hang = $urandom_range(0, 7) == 0;
            Rst = $urandom_range(0, 299) == 0;
        end
        tick();
        Rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
